// File: rtl/mem_copy_dma.sv
// mem_copy_dma
//   Bus initiator for a single-port byte memory. It copies a block of len bytes
//   from src_addr to dst_addr in strict forward order. Each byte takes one read
//   cycle followed by one write cycle. Addresses wrap modulo 2**ADDR_W.
//
// Ports
//   clk, rst_n                  system clock (rising edge), async active-low reset
//   start                       copy request, sampled only in IDLE
//   src_addr, dst_addr, len     copy descriptor, latched when start is accepted
//   abort                       (MEM_COPY_ABORT_EN only) early termination request
//   busy, done, bytes_done      status outputs
//   mem_addr, mem_read_en,
//   mem_write_en, mem_write_in  memory port, all driven from flops
//   mem_read_out                memory read data, combinational in the read cycle
//
// Build option
//   MEM_COPY_ABORT_EN adds the abort input. Without it, every copy runs to len.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// READ  | mem_read_en high, data captured at the closing edge
// WRITE | mem_write_en high, cnt/bytes_done advance at the closing edge
// DONE  | one-cycle done pulse, then back to IDLE
module mem_copy_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
`ifdef MEM_COPY_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   bytes_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_in,
  input  logic [DATA_W-1:0] mem_read_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   bytes_done_q, bytes_done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic [DATA_W-1:0] mem_write_in_q, mem_write_in_d;

  logic              abort_w;
  logic [ADDR_W:0]   cnt_inc;

`ifdef MEM_COPY_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      data_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      bytes_done_q   <= '0;
      mem_addr_q     <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_write_in_q <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      data_q         <= data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      bytes_done_q   <= bytes_done_d;
      mem_addr_q     <= mem_addr_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      mem_write_in_q <= mem_write_in_d;
    end
  end

  // Outputs are registered, so each branch computes the outputs for the
  // state being entered rather than the state being left.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    dst_d          = dst_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    data_d         = data_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    bytes_done_d   = bytes_done_q;
    mem_addr_d     = mem_addr_q;
    mem_read_en_d  = 1'b0;
    mem_write_en_d = 1'b0;
    mem_write_in_d = mem_write_in_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          src_d        = src_addr;
          dst_d        = dst_addr;
          len_d        = len;
          cnt_d        = '0;
          bytes_done_d = '0;
          if (len != '0) begin
            state_d       = READ;
            busy_d        = 1'b1;
            mem_read_en_d = 1'b1;
            mem_addr_d    = src_addr;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      READ: begin
        data_d = mem_read_out;
        if (abort_w) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d        = WRITE;
          mem_write_en_d = 1'b1;
          mem_addr_d     = dst_q + cnt_q[ADDR_W-1:0];
          mem_write_in_d = mem_read_out;
        end
      end

      WRITE: begin
        // The write in this cycle always completes, even when aborting.
        cnt_d        = cnt_inc;
        bytes_done_d = bytes_done_q + 1'b1;
        if (cnt_inc == len_q || abort_w) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d       = READ;
          mem_read_en_d = 1'b1;
          mem_addr_d    = src_q + cnt_inc[ADDR_W-1:0];
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign bytes_done   = bytes_done_q;
  assign mem_addr     = mem_addr_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_write_in = mem_write_in_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma
//   Directed bench for mem_copy_dma with a behavioural 256-byte memory.
//   The abort scenarios are built only when MEM_COPY_ABORT_EN is defined.
module tb_mem_copy_dma;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [8:0] len;
`ifdef MEM_COPY_ABORT_EN
  logic       abort;
`endif
  logic       busy;
  logic       done;
  logic [8:0] bytes_done;
  logic [7:0] mem_addr;
  logic       mem_read_en;
  logic       mem_write_en;
  logic [7:0] mem_write_in;
  logic [7:0] mem_read_out;

  logic [7:0] mem [256];

  int tests_run = 0;
  int tests_failed = 0;

  int         rd_cnt;
  int         wr_cnt;
  int         both_cnt;
  bit         done_seen;
  logic [7:0] rd_addrs[$];

  mem_copy_dma #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
`ifdef MEM_COPY_ABORT_EN
    .abort        (abort),
`endif
    .busy         (busy),
    .done         (done),
    .bytes_done   (bytes_done),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_write_in (mem_write_in),
    .mem_read_out (mem_read_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_out = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr] <= mem_write_in;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read_en) begin
        rd_cnt++;
        rd_addrs.push_back(mem_addr);
      end
      if (mem_write_en) wr_cnt++;
      if (mem_read_en && mem_write_en) both_cnt++;
      if (done) done_seen = 1'b1;
    end
  end

  task automatic clear_log();
    rd_cnt = 0;
    wr_cnt = 0;
    done_seen = 1'b0;
    rd_addrs.delete();
  endtask

  // Called at posedge+1; returns with cyc = cycle after the start edge in which
  // done is high (or the budget value if it never came).
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] l, output int cyc);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    tests_run++;
    if ({busy, done, mem_read_en, mem_write_en} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b expected 0000", {busy, done, mem_read_en, mem_write_en});
    end
    tests_run++;
    if ({mem_addr, mem_write_in, bytes_done} !== 25'd0) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wdata=%h bytes_done=%0d expected all 0", mem_addr, mem_write_in, bytes_done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_copy();
    int cyc;
    logic [7:0] exp_addr [4];
    for (int i = 0; i < 4; i++) begin
      mem[8'h10 + i] = 8'hA0 + 8'(i);
      mem[8'h80 + i] = 8'h00;
      exp_addr[i] = 8'h10 + 8'(i);
    end
    clear_log();
    run_copy(8'h10, 8'h80, 9'd4, cyc);
    tests_run++;
    if (cyc !== 9) begin
      tests_failed++;
      $display("FAIL t1_done_latency: got %0d expected 9", cyc);
    end
    tests_run++;
    if (bytes_done !== 9'd4 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_status: bytes_done=%0d busy=%b expected 4 0", bytes_done, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL t1_done_pulse: done=%b expected 0", done);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (mem[8'h80 + i] !== 8'hA0 + 8'(i)) begin
        tests_failed++;
        $display("FAIL t1_data[%0d]: got %h expected %h", i, mem[8'h80 + i], 8'hA0 + 8'(i));
      end
    end
    tests_run++;
    if (rd_addrs.size() != 4) begin
      tests_failed++;
      $display("FAIL t1_read_count: got %0d expected 4", rd_addrs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (rd_addrs[i] !== exp_addr[i]) begin
          tests_failed++;
          $display("FAIL t1_read_addr[%0d]: got %h expected %h", i, rd_addrs[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int cyc;
    clear_log();
    run_copy(8'h33, 8'h44, 9'd0, cyc);
    tests_run++;
    if (cyc !== 1) begin
      tests_failed++;
      $display("FAIL t2_done_latency: got %0d expected 1", cyc);
    end
    tests_run++;
    if (bytes_done !== 9'd0) begin
      tests_failed++;
      $display("FAIL t2_bytes_done: got %0d expected 0", bytes_done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rd_cnt != 0 || wr_cnt != 0) begin
      tests_failed++;
      $display("FAIL t2_no_strobes: reads=%0d writes=%0d expected 0 0", rd_cnt, wr_cnt);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    logic [7:0] exp_rd [3];
    logic [7:0] exp_wd [3];
    exp_rd[0] = 8'hFE; exp_rd[1] = 8'hFF; exp_rd[2] = 8'h00;
    exp_wd[0] = 8'h11; exp_wd[1] = 8'h22; exp_wd[2] = 8'h33;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33;
    mem[8'h01] = 8'h00; mem[8'h02] = 8'h00; mem[8'h03] = 8'h00;
    clear_log();
    run_copy(8'hFE, 8'h01, 9'd3, cyc);
    @(posedge clk); #1;
    tests_run++;
    if (rd_addrs.size() != 3) begin
      tests_failed++;
      $display("FAIL t3_read_count: got %0d expected 3", rd_addrs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (rd_addrs[i] !== exp_rd[i]) begin
          tests_failed++;
          $display("FAIL t3_read_addr[%0d]: got %h expected %h", i, rd_addrs[i], exp_rd[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (mem[8'h01 + i] !== exp_wd[i]) begin
        tests_failed++;
        $display("FAIL t3_data[%0d]: got %h expected %h", i, mem[8'h01 + i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_fill_and_ignored_start();
    int cyc;
    mem[8'h20] = 8'h5A;
    for (int i = 1; i <= 4; i++) mem[8'h20 + i] = 8'h00;
    mem[8'h25] = 8'hEE;
    clear_log();
    start = 1'b1; src_addr = 8'h20; dst_addr = 8'h21; len = 9'd4;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    // Second request mid-copy with a different descriptor; must be dropped.
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    start = 1'b1; src_addr = 8'h00; dst_addr = 8'hC0; len = 9'd9;
    @(posedge clk); #1; cyc++;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    tests_run++;
    if (cyc !== 9 || bytes_done !== 9'd4) begin
      tests_failed++;
      $display("FAIL t4_done: cycle=%0d bytes_done=%0d expected 9 4", cyc, bytes_done);
    end
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (mem[8'h20 + i] !== 8'h5A) begin
        tests_failed++;
        $display("FAIL t4_fill[%0d]: got %h expected 5a", i, mem[8'h20 + i]);
      end
    end
    tests_run++;
    if (mem[8'h25] !== 8'hEE || wr_cnt != 4) begin
      tests_failed++;
      $display("FAIL t4_extent: mem25=%h writes=%0d expected ee 4", mem[8'h25], wr_cnt);
    end
  endtask

  task automatic test_reset_mid_copy();
    for (int i = 0; i < 8; i++) begin
      mem[8'h40 + i] = 8'hC0 + 8'(i);
      mem[8'h90 + i] = 8'h00;
    end
    clear_log();
    start = 1'b1; src_addr = 8'h40; dst_addr = 8'h90; len = 9'd8;
    @(posedge clk); #1;            // cycle 1: READ
    start = 1'b0;
    @(posedge clk); #1;            // cycle 2: WRITE
    @(posedge clk); #1;            // cycle 3: READ
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, mem_read_en, mem_write_en, bytes_done} !== 13'd0) begin
      tests_failed++;
      $display("FAIL t5_async_clear: busy=%b done=%b rd=%b wr=%b bytes_done=%0d expected all 0",
               busy, done, mem_read_en, mem_write_en, bytes_done);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (done_seen || wr_cnt != 1) begin
      tests_failed++;
      $display("FAIL t5_partial: done_seen=%b writes=%0d expected 0 1", done_seen, wr_cnt);
    end
    tests_run++;
    if (mem[8'h90] !== 8'hC0 || mem[8'h91] !== 8'h00) begin
      tests_failed++;
      $display("FAIL t5_mem: mem90=%h mem91=%h expected c0 00", mem[8'h90], mem[8'h91]);
    end
  endtask

  task automatic test_full_len();
    int cyc;
    clear_log();
    run_copy(8'h00, 8'h00, 9'd256, cyc);
    tests_run++;
    if (cyc !== 513 || bytes_done !== 9'd256) begin
      tests_failed++;
      $display("FAIL full_len: cycle=%0d bytes_done=%0d expected 513 256", cyc, bytes_done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wr_cnt != 256 || rd_cnt != 256) begin
      tests_failed++;
      $display("FAIL full_len_strobes: reads=%0d writes=%0d expected 256 256", rd_cnt, wr_cnt);
    end
  endtask

`ifdef MEM_COPY_ABORT_EN
  task automatic abort_run(input int abort_cycle, output int cyc);
    start = 1'b1; src_addr = 8'h60; dst_addr = 8'hB0; len = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 1000) begin
      abort = (cyc == abort_cycle);
      @(posedge clk); #1;
      cyc++;
    end
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int cyc;
    for (int i = 0; i < 8; i++) begin
      mem[8'h60 + i] = 8'h70 + 8'(i);
      mem[8'hB0 + i] = 8'h00;
    end
    // Cycle 6 after start is the 3rd WRITE.
    clear_log();
    abort_run(6, cyc);
    tests_run++;
    if (cyc !== 7 || bytes_done !== 9'd3) begin
      tests_failed++;
      $display("FAIL t6_abort_write: cycle=%0d bytes_done=%0d expected 7 3", cyc, bytes_done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wr_cnt != 3 || mem[8'hB2] !== 8'h72 || mem[8'hB3] !== 8'h00) begin
      tests_failed++;
      $display("FAIL t6_abort_write_mem: writes=%0d memb2=%h memb3=%h expected 3 72 00",
               wr_cnt, mem[8'hB2], mem[8'hB3]);
    end
    // Cycle 3 after start is the 2nd READ: no write for that byte.
    clear_log();
    abort_run(3, cyc);
    tests_run++;
    if (cyc !== 4 || bytes_done !== 9'd1) begin
      tests_failed++;
      $display("FAIL t6_abort_read: cycle=%0d bytes_done=%0d expected 4 1", cyc, bytes_done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wr_cnt != 1) begin
      tests_failed++;
      $display("FAIL t6_abort_read_writes: got %0d expected 1", wr_cnt);
    end
  endtask
`endif

  task automatic test_strobe_exclusive();
    tests_run++;
    if (both_cnt != 0) begin
      tests_failed++;
      $display("FAIL strobe_exclusive: overlapping cycles=%0d expected 0", both_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
`ifdef MEM_COPY_ABORT_EN
    abort = 1'b0;
`endif
    both_cnt = 0;
    clear_log();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    test_reset();
    test_basic_copy();
    test_zero_len();
    test_wrap();
    test_fill_and_ignored_start();
    test_reset_mid_copy();
    test_full_len();
`ifdef MEM_COPY_ABORT_EN
    test_abort();
`endif
    test_strobe_exclusive();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
